// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, hazard-controller
// state and the bundled per-stage buffer load/flush controls.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        MEM_DONE
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } lc3b_pipe_ctrl;

endpackage

// File: rtl/pipeline_control_if.sv
// Pipeline controller bundle: cache handshakes, hazard inputs,
// stage-buffer controls and performance counters.
interface pipeline_control_if #(
    parameter int CNT_W = 16
);
    import lc3b_types::*;

    logic           imem_resp;
    logic           dmem_resp;
    logic           mem_read;
    logic           mem_write;
    logic           mem_br_taken;
    lc3b_reg        id_src1;
    lc3b_reg        id_src2;
    logic           id_use_src1;
    logic           id_use_src2;
    lc3b_reg        ex_dest;
    logic           ex_is_load;

    logic           imem_read;
    logic           dmem_read;
    logic           dmem_write;
    logic           load_mdr_hold;
    logic           load_pc;
    logic           pcmux_sel;
    logic           load_if_id;
    logic           load_id_ex;
    logic           load_ex_mem;
    logic           load_mem_wb;
    logic           flush_if_id;
    logic           flush_id_ex;
    logic           flush_ex_mem;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  imem_resp, dmem_resp, mem_read, mem_write,
        input  mem_br_taken, id_src1, id_src2,
        input  id_use_src1, id_use_src2, ex_dest, ex_is_load,
        output imem_read, dmem_read, dmem_write, load_mdr_hold,
        output load_pc, pcmux_sel,
        output load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        output flush_if_id, flush_id_ex, flush_ex_mem,
        output stall_count, flush_count
    );

    modport slave (
        output imem_resp, dmem_resp, mem_read, mem_write,
        output mem_br_taken, id_src1, id_src2,
        output id_use_src1, id_use_src2, ex_dest, ex_is_load,
        input  imem_read, dmem_read, dmem_write, load_mdr_hold,
        input  load_pc, pcmux_sel,
        input  load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        input  flush_if_id, flush_id_ex, flush_ex_mem,
        input  stall_count, flush_count
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the EX-stage load writes a register that the
// ID-stage instruction actually reads.
module hazard_detect
    import lc3b_types::*;
(
    input  logic    i_ex_is_load,
    input  lc3b_reg i_ex_dest,
    input  lc3b_reg i_id_src1,
    input  lc3b_reg i_id_src2,
    input  logic    i_use_src1,
    input  logic    i_use_src2,
    output logic    o_hazard
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1   = i_use_src1 & (i_id_src1 == i_ex_dest);
    assign w_hit2   = i_use_src2 & (i_id_src2 == i_ex_dest);
    assign o_hazard = i_ex_is_load & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipeline_control.sv
// Five-stage LC-3b hazard/stall controller: memory stalls, load-use
// bubbles, taken-branch redirects and saturating debug counters.
module pipeline_control
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    pipeline_control_if.master bus
);

    pipe_ctrl_state_t r_state;
    pipe_ctrl_state_t w_state_nxt;
    lc3b_pipe_ctrl    w_ctl;
    logic             w_load_pc;
    logic             w_pcmux_sel;
    logic             w_mem_access;
    logic             w_dmem_done;
    logic             w_advance;
    logic             w_hazard;
    logic             w_redirect;
    logic             w_stall;
    logic             w_not_done;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    assign w_mem_access = bus.mem_read | bus.mem_write;
    assign w_dmem_done  = ~w_mem_access | bus.dmem_resp
                        | (r_state == MEM_DONE);
    assign w_advance    = bus.imem_resp & w_dmem_done;
    assign w_redirect   = w_advance & bus.mem_br_taken;
    // a memory stall or a load-use bubble both count as a stall
    assign w_stall      = ~w_advance
                        | (~bus.mem_br_taken & w_hazard);
    assign w_not_done   = reset_n & (r_state != MEM_DONE);

    hazard_detect u_hazard (
        .i_ex_is_load (bus.ex_is_load),
        .i_ex_dest    (bus.ex_dest),
        .i_id_src1    (bus.id_src1),
        .i_id_src2    (bus.id_src2),
        .i_use_src1   (bus.id_use_src1),
        .i_use_src2   (bus.id_use_src2),
        .o_hazard     (w_hazard)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RUN;
        else          r_state <= w_state_nxt;
    end

    // next state: track whether the data access already completed
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_mem_access & ~bus.dmem_resp)
                    w_state_nxt = MEM_WAIT;
                else if (w_mem_access & ~w_advance)
                    w_state_nxt = MEM_DONE;
            end
            MEM_WAIT: begin
                if (bus.dmem_resp & w_advance)
                    w_state_nxt = RUN;
                else if (bus.dmem_resp)
                    w_state_nxt = MEM_DONE;
            end
            MEM_DONE: begin
                if (w_advance) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // stage-buffer controls, highest priority first
    always_comb begin
        w_ctl       = '0;
        w_load_pc   = 1'b0;
        w_pcmux_sel = 1'b0;
        priority case (1'b1)
            !reset_n: begin
                w_ctl.flush_if_id  = 1'b1;
                w_ctl.flush_id_ex  = 1'b1;
                w_ctl.flush_ex_mem = 1'b1;
            end
            !w_advance: begin
                w_load_pc = 1'b0;
            end
            w_redirect: begin
                w_ctl       = '1;
                w_load_pc   = 1'b1;
                w_pcmux_sel = 1'b1;
            end
            w_hazard: begin
                w_ctl.load_id_ex  = 1'b1;
                w_ctl.load_ex_mem = 1'b1;
                w_ctl.load_mem_wb = 1'b1;
                w_ctl.flush_id_ex = 1'b1;
            end
            default: begin
                w_ctl.load_if_id  = 1'b1;
                w_ctl.load_id_ex  = 1'b1;
                w_ctl.load_ex_mem = 1'b1;
                w_ctl.load_mem_wb = 1'b1;
                w_load_pc         = 1'b1;
            end
        endcase
    end

    // saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && !(&r_stall_count))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_redirect && !(&r_flush_count))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign bus.imem_read     = reset_n;
    assign bus.dmem_read     = bus.mem_read & w_not_done;
    assign bus.dmem_write    = bus.mem_write & w_not_done;
    assign bus.load_mdr_hold = reset_n & bus.dmem_resp
                             & bus.mem_read;
    assign bus.load_pc       = w_load_pc;
    assign bus.pcmux_sel     = w_pcmux_sel;
    assign bus.load_if_id    = w_ctl.load_if_id;
    assign bus.load_id_ex    = w_ctl.load_id_ex;
    assign bus.load_ex_mem   = w_ctl.load_ex_mem;
    assign bus.load_mem_wb   = w_ctl.load_mem_wb;
    assign bus.flush_if_id   = w_ctl.flush_if_id;
    assign bus.flush_id_ex   = w_ctl.flush_id_ex;
    assign bus.flush_ex_mem  = w_ctl.flush_ex_mem;
    assign bus.stall_count   = r_stall_count;
    assign bus.flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: vector table, directed
// corner sequences and randomized run against a behavioural model.
module tb_pipeline_control;
    import lc3b_types::*;

    localparam logic [12:0] FULL = 13'h1FFF;
    localparam logic [12:0] NOPC = 13'h1F7F;
    localparam logic [12:0] HMSK = 13'h1F5F;
    localparam logic [12:0] VN   = 13'b1_0_0_0_1_0_1111_000;
    localparam logic [12:0] VS   = 13'b1_0_0_0_0_0_0000_000;
    localparam logic [12:0] VB   = 13'b1_0_0_0_1_1_1111_111;
    localparam logic [12:0] VH   = 13'b1_0_0_0_0_0_0011_010;
    localparam logic [12:0] VRST = 13'b0_0_0_0_0_0_0000_111;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    bit          m_acked;
    int unsigned m_stall;
    int unsigned m_flush;

    always #5 clk = ~clk;

    pipeline_control_if #(.CNT_W(16)) bus ();

    pipeline_control #(.CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       nm;
        logic [5:0]  ctl;
        logic [2:0]  dest;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [1:0]  use_;
        logic [12:0] exp;
        logic [12:0] mask;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(string nm, logic [5:0] ctl,
                                logic [2:0] dest, logic [2:0] s1,
                                logic [2:0] s2, logic [1:0] use_,
                                logic [12:0] exp, logic [12:0] mask);
        vec_t v;
        v.nm = nm; v.ctl = ctl; v.dest = dest; v.s1 = s1;
        v.s2 = s2; v.use_ = use_; v.exp = exp; v.mask = mask;
        return v;
    endfunction

    function automatic logic [12:0] act_vec();
        return {bus.imem_read, bus.dmem_read, bus.dmem_write,
                bus.load_mdr_hold, bus.load_pc, bus.pcmux_sel,
                bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                bus.load_mem_wb, bus.flush_if_id, bus.flush_id_ex,
                bus.flush_ex_mem};
    endfunction

    function automatic int unsigned sat(int unsigned v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkm(string nm, logic [12:0] act,
                        logic [12:0] exp, logic [12:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got %b expected %b (mask %b)",
                     nm, act, exp, mask);
        end
    endtask

    task automatic drive(logic [5:0] ctl, logic [2:0] dest,
                         logic [2:0] s1, logic [2:0] s2,
                         logic [1:0] use_);
        {bus.imem_resp, bus.dmem_resp, bus.mem_read,
         bus.mem_write, bus.mem_br_taken, bus.ex_is_load} = ctl;
        bus.ex_dest = dest;
        bus.id_src1 = s1;
        bus.id_src2 = s2;
        {bus.id_use_src1, bus.id_use_src2} = use_;
    endtask

    // reference: stall until both fetch and data access are done,
    // then redirect > load-use bubble > normal advance
    task automatic model_out(output logic [12:0] e,
                             output logic [12:0] m,
                             output bit adv, output bit hz);
        bit acc;
        acc = bus.mem_read || bus.mem_write;
        adv = bus.imem_resp && (!acc || bus.dmem_resp || m_acked);
        hz  = bus.ex_is_load &&
              ((bus.id_use_src1 && bus.id_src1 == bus.ex_dest) ||
               (bus.id_use_src2 && bus.id_src2 == bus.ex_dest));
        e = '0;
        m = FULL;
        e[12] = 1'b1;
        e[11] = bus.mem_read && !m_acked;
        e[10] = bus.mem_write && !m_acked;
        e[9]  = bus.dmem_resp && bus.mem_read;
        if (!adv) m[7] = 1'b0;
        else if (bus.mem_br_taken) e[8:0] = VB[8:0];
        else if (hz) begin
            e[8:0] = VH[8:0];
            m[7] = 1'b0;
            m[5] = 1'b0;
        end else e[8:0] = VN[8:0];
    endtask

    // inputs driven at a negedge; returns at the following negedge
    task automatic cycle_check(string nm);
        logic [12:0] e;
        logic [12:0] m;
        bit adv;
        bit hz;
        bit acc;
        #1;
        model_out(e, m, adv, hz);
        chkm({nm, "_ctl"}, act_vec(), e, m);
        acc = bus.mem_read || bus.mem_write;
        @(posedge clk);
        if (!adv || (!bus.mem_br_taken && hz)) m_stall++;
        if (adv && bus.mem_br_taken) m_flush++;
        m_acked = !adv && (m_acked || (acc && bus.dmem_resp));
        @(negedge clk);
        chk({nm, "_stall_cnt"}, bus.stall_count, sat(m_stall));
        chk({nm, "_flush_cnt"}, bus.flush_count, sat(m_flush));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(6'b0, 3'd0, 3'd0, 3'd0, 2'b0);
        m_acked = 1'b0;
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        #1;
        chk("reset_outs", {19'd0, act_vec()}, {19'd0, VRST});
        chk("reset_stall_cnt", bus.stall_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] dest;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [1:0] u;
        logic [2:0] op;
        bit         br;
        bit         ld;
        bit         imem;
        bit         resp;

        tbl[0]  = mk("normal", 6'b100000, 0, 0, 0, 2'b00, VN, FULL);
        tbl[1]  = mk("fetch_stall", 6'b000000, 0, 0, 0, 2'b00, VS, NOPC);
        tbl[2]  = mk("read_hit", 6'b111000, 0, 0, 0, 2'b00,
                     13'b1_1_0_1_1_0_1111_000, FULL);
        tbl[3]  = mk("read_miss", 6'b101000, 0, 0, 0, 2'b00,
                     13'b1_1_0_0_0_0_0000_000, NOPC);
        tbl[4]  = mk("write_hit", 6'b110100, 0, 0, 0, 2'b00,
                     13'b1_0_1_0_1_0_1111_000, FULL);
        tbl[5]  = mk("branch", 6'b100010, 0, 0, 0, 2'b00, VB, FULL);
        tbl[6]  = mk("br_over_hz", 6'b100011, 2, 2, 0, 2'b10, VB, FULL);
        tbl[7]  = mk("hz_src1", 6'b100001, 2, 2, 5, 2'b10, VH, HMSK);
        tbl[8]  = mk("hz_src2", 6'b100001, 6, 0, 6, 2'b01, VH, HMSK);
        tbl[9]  = mk("hz_disabled", 6'b100001, 2, 2, 2, 2'b00, VN, FULL);
        tbl[10] = mk("nonload_match", 6'b100000, 4, 4, 4, 2'b11, VN, FULL);
        tbl[11] = mk("br_fetch_stall", 6'b000010, 0, 0, 0, 2'b00, VS, NOPC);
        tbl[12] = mk("br_read_miss", 6'b101010, 0, 0, 0, 2'b00,
                     13'b1_1_0_0_0_0_0000_000, NOPC);
        tbl[13] = mk("read_hit_hz", 6'b111001, 1, 1, 0, 2'b10,
                     13'b1_1_0_1_0_0_0011_010, HMSK);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            drive(tbl[i].ctl, tbl[i].dest, tbl[i].s1,
                  tbl[i].s2, tbl[i].use_);
            #1;
            chkm(tbl[i].nm, act_vec(), tbl[i].exp, tbl[i].mask);
        end

        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(6'b100000, 0, 0, 0, 2'b00);
            cycle_check("normal_flow");
        end
        chk("normal_stall_cnt", bus.stall_count, 0);

        do_reset();
        drive(6'b100001, 3'd3, 3'd1, 3'd3, 2'b11);
        #1;
        chk("lu_load_if_id", bus.load_if_id, 0);
        chk("lu_flush_id_ex", bus.flush_id_ex, 1);
        cycle_check("load_use");
        chk("lu_stall_cnt", bus.stall_count, 1);

        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive({c == 4, c == 2, 4'b0100}, 0, 0, 0, 2'b00);
            #1;
            chk($sformatf("wr_dmem_write_c%0d", c),
                bus.dmem_write, (c <= 2));
            if (c >= 3)
                chk($sformatf("wr_state_c%0d", c),
                    32'(dut.r_state), 32'(MEM_DONE));
            if (c == 4)
                chk("wr_loads", {bus.load_if_id, bus.load_id_ex,
                    bus.load_ex_mem, bus.load_mem_wb}, 4'hF);
            cycle_check("wr_pending");
        end

        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive({1'b1, c == 5, 4'b1010}, 0, 0, 0, 2'b00);
            #1;
            chk($sformatf("brs_load_pc_c%0d", c), bus.load_pc, (c == 5));
            if (c == 5) begin
                chk("brs_pcmux", bus.pcmux_sel, 1);
                chk("brs_flushes", {bus.flush_if_id, bus.flush_id_ex,
                    bus.flush_ex_mem}, 3'b111);
            end
            cycle_check("br_stall");
        end
        chk("brs_flush_cnt", bus.flush_count, 1);

        do_reset();
        repeat (65534) @(negedge clk);
        m_stall = 65534;
        chk("sat_pre", bus.stall_count, 16'hFFFE);
        for (int c = 0; c < 3; c++) begin
            drive(6'b000000, 0, 0, 0, 2'b00);
            cycle_check("sat");
        end
        chk("sat_hold", bus.stall_count, 16'hFFFF);

        do_reset();
        drive(6'b101000, 0, 0, 0, 2'b00);
        cycle_check("rst_mid_pre");
        chk("rst_mid_wait", 32'(dut.r_state), 32'(MEM_WAIT));
        chk("rst_mid_dread", bus.dmem_read, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_dread_drop", bus.dmem_read, 0);
        chk("rst_mid_outs", {19'd0, act_vec()}, {19'd0, VRST});
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_mid_state", 32'(dut.r_state), 32'(RUN));
        chk("rst_mid_stall", bus.stall_count, 0);
        chk("rst_mid_flush", bus.flush_count, 0);

        do_reset();
        op = 3'd0; br = 0; ld = 0; dest = 0; s1 = 0; s2 = 0; u = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 0 || act_vec() == 13'h0 || bus.load_mem_wb) begin
                op   = 3'($urandom_range(0, 2));
                br   = ($urandom_range(0, 5) == 0);
                ld   = $urandom_range(0, 1);
                dest = 3'($urandom_range(0, 3));
                s1   = 3'($urandom_range(0, 3));
                s2   = 3'($urandom_range(0, 3));
                u    = 2'($urandom_range(0, 3));
            end
            imem = ($urandom_range(0, 9) < 7);
            resp = (op != 0) && !m_acked &&
                   ($urandom_range(0, 9) < 4);
            drive({imem, resp, op == 1, op == 2, br, ld},
                  dest, s1, s2, u);
            cycle_check("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Hazard and stall controller for the five-stage LC-3b pipeline. It drives the `load` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage buffers and the PC load. It sequences the instruction- and data-memory handshakes and resolves three cases: memory stalls, load-use hazards and taken-branch redirects. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `CNT_W`, default 16: width of the performance counters.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_resp` in 1: I-cache response; fetch for the current PC is complete this cycle.
- `dmem_resp` in 1: D-cache response pulse.
- `mem_read`, `mem_write` in 1 each: MEM-stage control-word bits from the EX/MEM buffer.
- `mem_br_taken` in 1: branch, jump or trap resolved taken in MEM.
- `id_src1`, `id_src2` in `lc3b_reg`: source registers of the ID-stage instruction.
- `id_use_src1`, `id_use_src2` in 1 each: the ID-stage instruction reads that source.
- `ex_dest` in `lc3b_reg`: destination register of the EX-stage instruction.
- `ex_is_load` in 1: EX-stage instruction is LDR, LDB, LDI or LEA-free load class.
- `imem_read` out 1: instruction-fetch strobe.
- `dmem_read`, `dmem_write` out 1 each: data-access strobes.
- `load_mdr_hold` out 1: capture D-cache read data into the MEM-stage hold register.
- `load_pc` out 1: PC register load.
- `pcmux_sel` out 1: 0 selects PC+2, 1 selects the branch target.
- `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb` out 1 each: buffer loads.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1 each: buffer flushes. Flush has priority over load inside the buffer.
- `stall_count`, `flush_count` out `CNT_W` each: saturating performance counters.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `MEM_DONE`.
- `mem_access = mem_read | mem_write`.
- `dmem_done = ~mem_access | dmem_resp | (state == MEM_DONE)`.
- `advance = imem_resp & dmem_done`.
- D-cache strobes: `dmem_read = mem_read & (state != MEM_DONE)`. `dmem_write` follows the same rule with `mem_write`. A write is never reissued after its response.
- `load_mdr_hold = dmem_resp & mem_read`.
- `imem_read` = 1 whenever out of reset. Re-reading the same PC after a stall is harmless.
- FSM transitions:
  - `RUN`: `mem_access & ~dmem_resp` -> `MEM_WAIT`. `mem_access & dmem_resp & ~advance` -> `MEM_DONE`. Otherwise stay.
  - `MEM_WAIT`: `dmem_resp & advance` -> `RUN`. `dmem_resp & ~advance` -> `MEM_DONE`. Otherwise stay.
  - `MEM_DONE`: `advance` -> `RUN`. Otherwise stay.
- Priority, highest first:
  1. **Memory stall** (`~advance`): all loads 0, all flushes 0, `load_pc` = 0.
  2. **Redirect** (`advance & mem_br_taken`): `load_pc` = 1 and `pcmux_sel` = 1. All loads 1. `flush_if_id`, `flush_id_ex` and `flush_ex_mem` = 1.
  3. **Load-use** (`advance & ex_is_load` and an enabled `id_srcN == ex_dest`): `load_pc` = 0 and `load_if_id` = 0. `flush_id_ex` = 1 (bubble). `load_ex_mem` and `load_mem_wb` = 1.
  4. **Normal**: all loads 1, `load_pc` = 1, `pcmux_sel` = 0, no flush.
- Counters, both saturating at all-ones:
  - `stall_count` +1 on each cycle of case 1 or case 3.
  - `flush_count` +1 on each cycle of case 2.
- A branch in MEM during a memory stall is not lost. It takes effect on the first advancing cycle.

## Timing
- Loads, flushes, `load_pc`, `pcmux_sel`, strobes and `load_mdr_hold` are combinational from the current inputs and state, with zero-cycle latency.
- State and counters are registered.
- While `reset_n` = 0, asynchronously:
  - state is `RUN` and both counters are 0;
  - all strobes, loads, `load_pc`, `pcmux_sel` and `load_mdr_hold` are 0;
  - all three flush outputs are 1.
- Reset asserted mid-access drops the strobes immediately. The cache must tolerate an abandoned request.
- The redirect costs 3 bubble cycles, all flushed in the same edge.
- The load-use hazard costs 1 bubble cycle.

## Structure
- `lc3b_types` holds:
  - the `pipe_ctrl_state_t` enum (`RUN`, `MEM_WAIT`, `MEM_DONE`);
  - the existing `lc3b_reg` type;
  - a new `lc3b_pipe_ctrl` struct bundling the per-stage load and flush bits.
- One sub-module, `hazard_detect`: purely combinational load-use comparison, reused later for forwarding.

## Test plan
- **Normal flow.** `imem_resp` = 1 every cycle, no memory op -> all loads 1 every cycle, no flushes, `stall_count` stays 0.
- **Load-use.** `ex_is_load` = 1, `ex_dest` = R3, `id_src2` = R3 with its enable set -> one cycle with `load_if_id` = 0 and `flush_id_ex` = 1; `stall_count` = 1.
- **Write with fetch still pending.** `mem_write` = 1, `dmem_resp` in cycle 2, `imem_resp` only in cycle 4 -> `dmem_write` high in cycles 0-2 and low in 3-4; state is `MEM_DONE` in cycles 3-4; all stages advance in cycle 4.
- **Branch during data stall.** `mem_br_taken` = 1 during a 5-cycle data stall -> no redirect until the `dmem_resp` cycle. That cycle shows `pcmux_sel` = 1 and all three flushes; `flush_count` = 1.
- **Counter saturation.** Preload `stall_count` to 0xFFFE and hold a stall for 3 cycles -> the counter holds at 0xFFFF.
- **Reset mid-access.** Drop `reset_n` while in `MEM_WAIT` -> `dmem_read` falls without waiting for a clock; after release, state is `RUN` and both counters read 0.
